capture_write_scheduler: RTL and testbench
==========================================

# capture_write_scheduler

Sequences frame-buffer writes for the image capture path. Per captured line it issues one 72-bit S2MM write command, with address, byte count and tag, to the memory management unit's command channel. It tracks outstanding commands against returned write statuses and rotates through a ring of frame buffers in external memory. It sits between the capture front-end (frame/line strobes) and the memory management unit, and reports completed buffers to downstream readers.

## Interface
Parameters:
- LINES, 480, lines per frame (commands per frame)
- LINE_BYTES, 640, bytes per line (command BTT, < 2^23)
- NUM_BUFFERS, 3, frame buffers in ring (1..16)
- BASE_ADDR, 32'h1000_0000, address of buffer 0
- FRAME_STRIDE, 32'h0004_B000, address step between buffers
- MAX_OUTSTANDING, 4, max accepted commands without status (1..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- resetN  in  1  synchronous active-low reset
- enable  in  1  permits starting a new frame
- frameStart  in  1  one-cycle strobe, start of frame
- lineStart  in  1  one-cycle strobe, a line is about to be streamed
- commandData  out  72  S2MM command word
- commandPulse  out  1  command valid
- receiverCommandReady  in  1  command ready
- statusData  in  8  [7] OKAY, [3:0] tag
- statusValid  in  1  status valid
- statusReady  out  1  status ready
- frameDone  out  1  one-cycle strobe, frame fully written
- frameError  out  1  qualifies frameDone; frame had a bad status
- doneBuffer  out  4  buffer index of the finished frame, valid with frameDone
- busy  out  1  state != IDLE
- errorFlag  out  1  sticky error, cleared only by reset
- dropCount  out  16  lines dropped, saturating

## Operation
- **Command word layout:**
  - [22:0] BTT = LINE_BYTES; [23] = 1 (INCR); [29:24] = 0; [30] EOF = 1; [31] = 0.
  - [63:32] address; [67:64] tag = line index mod 16; [71:68] = 0.
- **FSM states:** IDLE, ARMED, ISSUE, DRAIN, DONE.
  - IDLE: on frameStart with enable=1, load lineAddr = bufBase and lineIdx = 0, clear the frame error, go to ARMED. frameStart outside IDLE is ignored.
  - ARMED: on lineStart with outstanding < MAX_OUTSTANDING, register the command and go to ISSUE. A lineStart with outstanding full increments dropCount and sets errorFlag; the state stays ARMED.
  - ISSUE: commandPulse=1 and commandData held stable until receiverCommandReady=1. On that handshake: outstanding += 1, lineAddr += LINE_BYTES, lineIdx += 1. Then go to DRAIN if the accepted line was LINES-1, else to ARMED. A lineStart during ISSUE is dropped and counted.
  - DRAIN: wait until outstanding == 0, then go to DONE.
  - DONE: one cycle. frameDone=1, doneBuffer = current index, frameError = frame error flag. Advance bufIdx and bufBase (bufBase += FRAME_STRIDE). After NUM_BUFFERS-1, wrap to index 0 and BASE_ADDR. Go to IDLE.
- **enable:** deassertion mid-frame does not abort; the frame completes, then the FSM stays in IDLE.
- **Status handling:**
  - statusReady = 1 at all times after reset.
  - On statusValid, outstanding -= 1, saturating at 0. A status arriving with outstanding == 0 is ignored (covers stale statuses after reset).
  - OKAY=0, or tag != expected tag, sets both frame error and errorFlag. Expected tag is the oldest unacknowledged line index mod 16; statuses return in order.
- **Simultaneous accept and status:** outstanding is unchanged.
- **Widths:** address arithmetic is 32-bit and wraps modulo 2^32. dropCount saturates at 16'hFFFF.

## Timing
- **Reset values:** all outputs 0 (commandData=0, statusReady=0 during reset). State IDLE; bufIdx 0; bufBase = BASE_ADDR.
- **Latency:** lineStart in ARMED at cycle N gives commandPulse=1 with valid commandData at N+1. Minimum of one cycle in ISSUE.
- **Command handshake:** a transfer happens on a cycle with commandPulse & receiverCommandReady. commandPulse is 0 the following cycle.
- **Frame completion:** the last status, arriving at cycle M while in DRAIN, gives DONE/frameDone at M+1 and IDLE at M+2.
- **Reset mid-operation:** the next cycle is IDLE with all state cleared. No command is held across reset.

## Structure
- Shared package `capture_pkg` holds:
  - command field offsets and widths, plus the CMD_TYPE_INCR and CMD_EOF constants;
  - status bit positions;
  - the FSM state enum.
- One sub-module, `outstanding_tracker`: outstanding counter, expected-tag counter and status checking. Outputs are full, empty and statusBad.

## Test plan
Bench parameters: LINES=4, LINE_BYTES=16, NUM_BUFFERS=2, BASE_ADDR=32'h1000, FRAME_STRIDE=32'h100, MAX_OUTSTANDING=2.
- Single frame, ready always 1, statuses OKAY with tags 0..3 → commands 72'h0_0_00001000_40800010 through 72'h0_3_00001030_40800010. frameDone=1, doneBuffer=0, frameError=0.
- Three frames → second frame line 0 address 32'h1100, third frame wraps to 32'h1000. doneBuffer sequence 0, 1, 0.
- receiverCommandReady low for 5 cycles during ISSUE → commandData stable and commandPulse held. Exactly one accept; outstanding=1.
- Two lines accepted with no status, then a third lineStart → dropCount=1, errorFlag=1. Lines still issued after statuses return; frameDone only after 4 accepted lines.
- Status with OKAY=0 on line 2 → errorFlag=1. frameDone accompanied by frameError=1; the next frame reports frameError=0.
- Reset asserted in ISSUE, then a stale status arrives → outputs at reset values, outstanding stays 0, no error.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the capture write scheduler: S2MM command field
// layout, status bit positions and the scheduler state encoding.
package capture_pkg;

   // S2MM command word field positions
   localparam int CMD_W        = 72;
   localparam int CMD_BTT_LSB  = 0;
   localparam int CMD_BTT_W    = 23;
   localparam int CMD_TYPE_BIT = 23;
   localparam int CMD_DSA_LSB  = 24;
   localparam int CMD_DSA_W    = 6;
   localparam int CMD_EOF_BIT  = 30;
   localparam int CMD_DRR_BIT  = 31;
   localparam int CMD_ADDR_LSB = 32;
   localparam int CMD_ADDR_W   = 32;
   localparam int CMD_TAG_LSB  = 64;
   localparam int CMD_TAG_W    = 4;
   localparam int CMD_RSVD_LSB = 68;
   localparam int CMD_RSVD_W   = 4;

   localparam logic CMD_TYPE_INCR = 1'b1;
   localparam logic CMD_EOF       = 1'b1;

   // Status word positions
   localparam int STATUS_OKAY_BIT = 7;
   localparam int STATUS_TAG_LSB  = 0;
   localparam int STATUS_TAG_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Assemble one line command; the DSA, DRR and reserved fields stay zero.
   function automatic logic [CMD_W-1:0] build_cmd(
      input logic [CMD_BTT_W-1:0]  btt,
      input logic [CMD_ADDR_W-1:0] addr,
      input logic [CMD_TAG_W-1:0]  tag
   );
      logic [CMD_W-1:0] cmd;
      cmd = '0;
      cmd[CMD_BTT_LSB +: CMD_BTT_W]   = btt;
      cmd[CMD_TYPE_BIT]               = CMD_TYPE_INCR;
      cmd[CMD_EOF_BIT]                = CMD_EOF;
      cmd[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
      cmd[CMD_TAG_LSB +: CMD_TAG_W]   = tag;
      return cmd;
   endfunction

endpackage

// File: rtl/outstanding_tracker.sv
// Counts accepted-but-unacknowledged commands and checks each returning
// status against the next expected tag (statuses come back in order).
module outstanding_tracker
   import capture_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
)(
   input  logic       clk,
   input  logic       resetN,
   input  logic       clear_tag,
   input  logic       accept,
   input  logic       status_valid,
   input  logic [7:0] status_data,
   output logic       full,
   output logic       empty,
   output logic       will_empty,
   output logic       status_bad
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   logic [3:0] count;
   logic [3:0] count_next;
   logic [3:0] exp_tag;
   logic       counted;
   logic       unused_status_bits;

   assign unused_status_bits = &{1'b0, status_data[6:4]};

   // A status only counts while something is outstanding; stale ones are dropped silently.
   always_comb begin
      counted    = status_valid && (count != 4'd0);
      status_bad = counted &&
                   (!status_data[STATUS_OKAY_BIT] ||
                    (status_data[STATUS_TAG_LSB +: STATUS_TAG_W] != exp_tag));
      count_next = count;
      if (accept && !counted) begin
         count_next = count + 4'd1;
      end else if (!accept && counted) begin
         count_next = count - 4'd1;
      end
   end

   assign full       = (count >= MAX_CNT);
   assign empty      = (count == 4'd0);
   assign will_empty = (count_next == 4'd0);

   // Outstanding count and expected tag; the tag restarts with every frame.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         count   <= 4'd0;
         exp_tag <= 4'd0;
      end else begin
         count <= count_next;
         if (clear_tag) begin
            exp_tag <= 4'd0;
         end else if (counted) begin
            exp_tag <= exp_tag + 4'd1;
         end
      end
   end

endmodule

// File: rtl/capture_write_scheduler.sv
// Issues one S2MM write command per captured line, tracks outstanding
// commands against returned statuses and rotates through a ring of frame
// buffers, reporting each finished frame downstream.
module capture_write_scheduler
   import capture_pkg::*;
#(
   parameter int          LINES           = 480,
   parameter int          LINE_BYTES      = 640,
   parameter int          NUM_BUFFERS     = 3,
   parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
   parameter logic [31:0] FRAME_STRIDE    = 32'h0004_B000,
   parameter int          MAX_OUTSTANDING = 4
)(
   input  logic        clk,
   input  logic        resetN,
   input  logic        enable,
   input  logic        frameStart,
   input  logic        lineStart,
   output logic [71:0] commandData,
   output logic        commandPulse,
   input  logic        receiverCommandReady,
   input  logic [7:0]  statusData,
   input  logic        statusValid,
   output logic        statusReady,
   output logic        frameDone,
   output logic        frameError,
   output logic [3:0]  doneBuffer,
   output logic        busy,
   output logic        errorFlag,
   output logic [15:0] dropCount
);

   localparam int LIDX_W = ($clog2(LINES + 1) > 4) ? $clog2(LINES + 1) : 4;
   localparam logic [LIDX_W-1:0]    LAST_LINE = LIDX_W'(LINES - 1);
   localparam logic [3:0]           LAST_BUF  = 4'(NUM_BUFFERS - 1);
   localparam logic [CMD_BTT_W-1:0] BTT       = CMD_BTT_W'(LINE_BYTES);
   localparam logic [31:0]          LINE_STEP = 32'(LINE_BYTES);

   state_t            state;
   logic [31:0]       line_addr;
   logic [31:0]       buf_base;
   logic [LIDX_W-1:0] line_idx;
   logic [3:0]        buf_idx;
   logic              frame_err;

   logic accept;
   logic status_fire;
   logic clear_tag;
   logic full;
   logic empty;
   logic will_empty;
   logic status_bad;

   assign accept      = commandPulse & receiverCommandReady;
   assign status_fire = statusValid & statusReady;
   assign clear_tag   = (state == ST_IDLE) && frameStart && enable;

   outstanding_tracker #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_tracker (
      .clk          (clk),
      .resetN       (resetN),
      .clear_tag    (clear_tag),
      .accept       (accept),
      .status_valid (status_fire),
      .status_data  (statusData),
      .full         (full),
      .empty        (empty),
      .will_empty   (will_empty),
      .status_bad   (status_bad)
   );

   // Frame sequencing FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= ST_IDLE;
         line_addr    <= 32'd0;
         buf_base     <= BASE_ADDR;
         line_idx     <= '0;
         buf_idx      <= 4'd0;
         frame_err    <= 1'b0;
         commandData  <= '0;
         commandPulse <= 1'b0;
         statusReady  <= 1'b0;
         frameDone    <= 1'b0;
         frameError   <= 1'b0;
         doneBuffer   <= 4'd0;
         busy         <= 1'b0;
         errorFlag    <= 1'b0;
         dropCount    <= 16'd0;
      end else begin
         statusReady <= 1'b1;
         if (status_bad) begin
            frame_err <= 1'b1;
            errorFlag <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (frameStart && enable) begin
                  line_addr <= buf_base;
                  line_idx  <= '0;
                  frame_err <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_ARMED;
               end
            end

            ST_ARMED: begin
               if (lineStart) begin
                  if (!full) begin
                     commandData  <= build_cmd(BTT, line_addr, line_idx[3:0]);
                     commandPulse <= 1'b1;
                     state        <= ST_ISSUE;
                  end else begin
                     if (dropCount != 16'hFFFF) begin
                        dropCount <= dropCount + 16'd1;
                     end
                     errorFlag <= 1'b1;
                  end
               end
            end

            ST_ISSUE: begin
               if (lineStart && (dropCount != 16'hFFFF)) begin
                  dropCount <= dropCount + 16'd1;
               end
               if (receiverCommandReady) begin
                  commandPulse <= 1'b0;
                  line_addr    <= line_addr + LINE_STEP;
                  line_idx     <= line_idx + 1'b1;
                  state        <= (line_idx == LAST_LINE) ? ST_DRAIN : ST_ARMED;
               end
            end

            ST_DRAIN: begin
               // Leave as soon as the final status lands so frameDone follows it by one cycle.
               if (empty || will_empty) begin
                  frameDone  <= 1'b1;
                  frameError <= frame_err | status_bad;
                  doneBuffer <= buf_idx;
                  state      <= ST_DONE;
               end
            end

            ST_DONE: begin
               frameDone  <= 1'b0;
               frameError <= 1'b0;
               doneBuffer <= 4'd0;
               if (buf_idx == LAST_BUF) begin
                  buf_idx  <= 4'd0;
                  buf_base <= BASE_ADDR;
               end else begin
                  buf_idx  <= buf_idx + 4'd1;
                  buf_base <= buf_base + FRAME_STRIDE;
               end
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_capture_write_scheduler.sv
// Randomised scoreboard bench for capture_write_scheduler: the stimulus side
// predicts commands and frame completions from frame/line arithmetic, and an
// independent monitor compares them whenever the DUT presents them.
module tb_capture_write_scheduler;

   localparam int          LINES       = 4;
   localparam int          LINE_BYTES  = 16;
   localparam int          NUM_BUFFERS = 2;
   localparam logic [31:0] BASE        = 32'h1000;
   localparam logic [31:0] STRIDE      = 32'h100;
   localparam int          MAXO        = 2;

   logic        clk;
   logic        resetN;
   logic        enable;
   logic        frameStart;
   logic        lineStart;
   logic [71:0] commandData;
   logic        commandPulse;
   logic        receiverCommandReady;
   logic [7:0]  statusData;
   logic        statusValid;
   logic        statusReady;
   logic        frameDone;
   logic        frameError;
   logic [3:0]  doneBuffer;
   logic        busy;
   logic        errorFlag;
   logic [15:0] dropCount;

   capture_write_scheduler #(
      .LINES           (LINES),
      .LINE_BYTES      (LINE_BYTES),
      .NUM_BUFFERS     (NUM_BUFFERS),
      .BASE_ADDR       (BASE),
      .FRAME_STRIDE    (STRIDE),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk                  (clk),
      .resetN               (resetN),
      .enable               (enable),
      .frameStart           (frameStart),
      .lineStart            (lineStart),
      .commandData          (commandData),
      .commandPulse         (commandPulse),
      .receiverCommandReady (receiverCommandReady),
      .statusData           (statusData),
      .statusValid          (statusValid),
      .statusReady          (statusReady),
      .frameDone            (frameDone),
      .frameError           (frameError),
      .doneBuffer           (doneBuffer),
      .busy                 (busy),
      .errorFlag            (errorFlag),
      .dropCount            (dropCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   // Scoreboard queues
   logic [71:0] exp_cmd_q[$];
   logic [4:0]  exp_done_q[$];

   // Reference model state
   int         m_out;
   int         m_drops;
   int         m_buf;
   int         m_line;
   bit         m_err_flag;
   bit         m_frame_err;
   logic [3:0] pend_tags[$];

   bit ready_rand;
   bit ready_force;

   task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected command: buffer b, line l of that frame.
   function automatic logic [71:0] exp_word(input int b, input int l);
      logic [31:0] a;
      a = BASE + STRIDE * 32'(b) + 32'(LINE_BYTES * l);
      return {4'h0, 4'(l % 16), a, 1'b0, 1'b1, 6'h00, 1'b1, 23'(LINE_BYTES)};
   endfunction

   // Command-ready driver
   initial begin
      receiverCommandReady = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         receiverCommandReady = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
      end
   end

   // Monitor: compares commands and frame reports as the DUT presents them
   bit          prev_held;
   bit          prev_fire;
   logic [71:0] prev_data;
   always @(negedge clk) begin
      if (!resetN) begin
         prev_held = 1'b0;
         prev_fire = 1'b0;
      end else begin
         if (prev_held) begin
            check("cmd_pulse_held", commandPulse, 1);
            check("cmd_data_stable", commandData, prev_data);
         end
         if (prev_fire) check("cmd_pulse_drop", commandPulse, 0);
         prev_fire = commandPulse && receiverCommandReady;
         prev_held = commandPulse && !receiverCommandReady;
         prev_data = commandData;
         if (prev_fire) begin
            if (exp_cmd_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_cmd: got %h expected none", commandData);
            end else begin
               check("cmd_word", commandData, exp_cmd_q.pop_front());
            end
         end
         if (frameDone) begin
            if (exp_done_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_frame_done: buf %0d err %0d expected none", doneBuffer, frameError);
            end else begin
               check("frame_done_err_buf", {frameError, doneBuffer}, exp_done_q.pop_front());
            end
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_cmd_data", commandData, 0);
      check("rst_cmd_pulse", commandPulse, 0);
      check("rst_status_ready", statusReady, 0);
      check("rst_frame_done", frameDone, 0);
      check("rst_frame_error", frameError, 0);
      check("rst_done_buffer", doneBuffer, 0);
      check("rst_busy", busy, 0);
      check("rst_error_flag", errorFlag, 0);
      check("rst_drop_count", dropCount, 0);
   endtask

   task automatic wait_pulse_low();
      for (int k = 0; k < 100 && commandPulse; k++) tick();
      if (commandPulse) begin
         n_cmp++;
         n_fail++;
         $display("FAIL cmd_accept_timeout: pulse %0d expected 0", commandPulse);
      end
   endtask

   // Model decision for a lineStart seen while waiting for a line.
   task automatic model_line(output bit issued);
      if (m_out >= MAXO) begin
         if (m_drops < 65535) m_drops++;
         m_err_flag = 1'b1;
         issued = 1'b0;
      end else begin
         exp_cmd_q.push_back(exp_word(m_buf, m_line));
         pend_tags.push_back(4'(m_line % 16));
         m_line++;
         m_out++;
         issued = 1'b1;
      end
   endtask

   task automatic send_line(output bit issued);
      model_line(issued);
      lineStart = 1'b1;
      tick();
      lineStart = 1'b0;
      if (issued) wait_pulse_low();
      check("drop_count", dropCount, m_drops);
      check("error_flag_line", errorFlag, m_err_flag);
   endtask

   task automatic send_status(input bit bad_okay, input bit bad_tag);
      logic [3:0] t;
      t = pend_tags.pop_front();
      m_out--;
      if (bad_okay || bad_tag) begin
         m_frame_err = 1'b1;
         m_err_flag  = 1'b1;
      end
      if (m_line == LINES && pend_tags.size() == 0) begin
         exp_done_q.push_back({m_frame_err, 4'(m_buf)});
         m_buf = (m_buf + 1) % NUM_BUFFERS;
      end
      statusData  = {~bad_okay, 3'b000, bad_tag ? (t ^ 4'h1) : t};
      statusValid = 1'b1;
      tick();
      statusValid = 1'b0;
      statusData  = 8'h00;
      check("error_flag_status", errorFlag, m_err_flag);
   endtask

   task automatic start_frame();
      enable     = 1'b1;
      frameStart = 1'b1;
      tick();
      frameStart  = 1'b0;
      m_line      = 0;
      m_frame_err = 1'b0;
      check("busy_start", busy, 1);
   endtask

   // policy 0: status right after each line; 1: random; 2: status only when forced by a drop
   task automatic run_frame(input int policy, input int bad_line);
      while (m_line < LINES) begin
         bit iss;
         if (policy == 1) begin
            while (pend_tags.size() > 0 && $urandom_range(0, 1) == 1)
               send_status($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
         end
         send_line(iss);
         if (!iss) send_status(1'b0, 1'b0);
         else if (policy == 0) send_status((m_line - 1) == bad_line, 1'b0);
      end
      while (pend_tags.size() > 0)
         send_status(policy == 1 && $urandom_range(0, 9) == 0, policy == 1 && $urandom_range(0, 19) == 0);
      repeat (3) tick();
      check("busy_idle", busy, 0);
   endtask

   initial begin
      bit iss;
      resetN      = 1'b0;
      enable      = 1'b0;
      frameStart  = 1'b0;
      lineStart   = 1'b0;
      statusData  = 8'h00;
      statusValid = 1'b0;
      ready_force = 1'b1;
      ready_rand  = 1'b0;
      m_out = 0; m_drops = 0; m_buf = 0; m_line = 0;
      m_err_flag = 1'b0; m_frame_err = 1'b0;

      repeat (3) tick();
      check_reset_outputs();
      resetN = 1'b1;
      tick();
      check("status_ready", statusReady, 1);

      // frameStart ignored while disabled
      enable     = 1'b0;
      frameStart = 1'b1;
      tick();
      frameStart = 1'b0;
      tick();
      check("busy_disabled", busy, 0);

      // Three clean frames: buffer ring 0, 1, 0
      repeat (3) begin
         start_frame();
         run_frame(0, -1);
      end

      // Command held with ready low; a lineStart during ISSUE is dropped
      start_frame();
      ready_force = 1'b0;
      tick();
      tick();
      model_line(iss);
      lineStart = 1'b1;
      tick();
      lineStart = 1'b0;
      tick();
      lineStart = 1'b1;
      if (m_drops < 65535) m_drops++;
      tick();
      lineStart = 1'b0;
      repeat (3) tick();
      check("drop_in_issue", dropCount, m_drops);
      check("pulse_while_held", commandPulse, 1);
      ready_force = 1'b1;
      wait_pulse_low();
      run_frame(0, -1);

      // Outstanding limit forces drops
      start_frame();
      run_frame(2, -1);

      // Bad status on line 2, then a clean frame
      start_frame();
      run_frame(0, 2);
      start_frame();
      run_frame(0, -1);

      // Reset in ISSUE, then a stale status
      start_frame();
      ready_force = 1'b0;
      tick();
      tick();
      lineStart = 1'b1;
      tick();
      lineStart = 1'b0;
      tick();
      tick();
      resetN = 1'b0;
      tick();
      exp_cmd_q.delete();
      pend_tags.delete();
      m_out = 0; m_drops = 0; m_buf = 0; m_line = 0;
      m_err_flag = 1'b0; m_frame_err = 1'b0;
      check_reset_outputs();
      ready_force = 1'b1;
      resetN = 1'b1;
      tick();
      statusData  = 8'h80;
      statusValid = 1'b1;
      tick();
      statusValid = 1'b0;
      statusData  = 8'h00;
      tick();
      tick();
      check("stale_error_flag", errorFlag, 0);
      check("stale_busy", busy, 0);
      check("stale_drop_count", dropCount, 0);
      start_frame();
      run_frame(2, -1);

      // Random ready and status timing
      ready_rand = 1'b1;
      repeat (6) begin
         start_frame();
         run_frame(1, -1);
      end
      ready_rand = 1'b0;
      repeat (3) tick();

      check("cmd_queue_empty", exp_cmd_q.size(), 0);
      check("done_queue_empty", exp_done_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
